// File: rtl/dmi_master.sv
// dmi_master: DMI request initiator with busy retry; optional response timeout and drain when DMI_MASTER_TIMEOUT_EN is defined
module dmi_master #(
  parameter int ADDR_W    = 7,
  parameter int MAX_RETRY = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [1:0]        rsp_status,
  output logic              dmi_req_valid,
  input  logic              dmi_req_ready,
  output logic [1:0]        dmi_req_bits_op,
  output logic [ADDR_W-1:0] dmi_req_bits_addr,
  output logic [31:0]       dmi_req_bits_data,
  input  logic              dmi_resp_valid,
  output logic              dmi_resp_ready,
  input  logic [31:0]       dmi_resp_bits_data,
  input  logic [1:0]        dmi_resp_bits_resp
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;
  state_e state_q, state_d;
  logic [1:0] op_q, op_d, status_q, status_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, data_q, data_d;
  logic [3:0] retry_q, retry_d;
  logic [15:0] tmo_q, tmo_d;
  logic drain_q, drain_d;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    data_d = data_q;
    status_d = status_q;
    retry_d = retry_q;
    tmo_d = tmo_q;
    drain_d = drain_q && !dmi_resp_valid;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready) begin
        op_d = cmd_op == 2'd3 ? 2'd0 : cmd_op;
        addr_d = cmd_addr;
        wdata_d = cmd_wdata;
        retry_d = 4'd0;
        state_d = REQ;
      end
      REQ: if (dmi_req_ready) begin
        tmo_d = 16'd0;
        state_d = RESP;
      end
      RESP: if (dmi_resp_valid) begin
        if (dmi_resp_bits_resp == 2'd3 && retry_q < 4'(MAX_RETRY)) begin
          retry_d = retry_q + 4'd1;
          state_d = REQ;
        end else begin
          data_d = dmi_resp_bits_data;
          status_d = dmi_resp_bits_resp == 2'd1 ? 2'd2 : dmi_resp_bits_resp;
          state_d = DONE;
        end
      end
`ifdef DMI_MASTER_TIMEOUT_EN
      else if (tmo_q == 16'(TIMEOUT - 1)) begin
        status_d = 2'd1;
        drain_d = 1'b1;
        state_d = DONE;
      end else tmo_d = tmo_q + 16'd1;
`endif
      default: if (rsp_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      op_q <= 2'd0;
      addr_q <= '0;
      wdata_q <= 32'd0;
      data_q <= 32'd0;
      status_q <= 2'd0;
      retry_q <= 4'd0;
      tmo_q <= 16'd0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      data_q <= data_d;
      status_q <= status_d;
      retry_q <= retry_d;
`ifdef DMI_MASTER_TIMEOUT_EN
      tmo_q <= tmo_d;
      drain_q <= drain_d;
`else
      tmo_q <= 16'd0;
      drain_q <= 1'b0;
`endif
    end
  end
  assign cmd_ready = state_q == IDLE && !drain_q;
  assign rsp_valid = state_q == DONE;
  assign rsp_data = data_q;
  assign rsp_status = status_q;
  assign dmi_req_valid = state_q == REQ;
  assign dmi_req_bits_op = op_q;
  assign dmi_req_bits_addr = addr_q;
  assign dmi_req_bits_data = wdata_q;
  assign dmi_resp_ready = state_q == RESP || drain_q;
endmodule

// File: tb/tb_dmi_master.sv
// tb_dmi_master: directed self-checking bench for dmi_master
module tb_dmi_master;
  logic clk = 0, resetn = 0;
  logic cmd_valid = 0, rsp_ready = 0, dmi_req_ready = 0, dmi_resp_valid = 0;
  logic [1:0] cmd_op = 0, dmi_resp_bits_resp = 0;
  logic [6:0] cmd_addr = 0;
  logic [31:0] cmd_wdata = 0, dmi_resp_bits_data = 0;
  logic cmd_ready, rsp_valid, dmi_req_valid, dmi_resp_ready;
  logic [31:0] rsp_data, dmi_req_bits_data;
  logic [1:0] rsp_status, dmi_req_bits_op;
  logic [6:0] dmi_req_bits_addr;
  int cmps = 0, errs = 0, req_cnt = 0, n0;
  dmi_master #(.ADDR_W(7), .MAX_RETRY(2), .TIMEOUT(16)) dut (
    .clock(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready), .dmi_req_bits_op(dmi_req_bits_op),
    .dmi_req_bits_addr(dmi_req_bits_addr), .dmi_req_bits_data(dmi_req_bits_data),
    .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
    .dmi_resp_bits_data(dmi_resp_bits_data), .dmi_resp_bits_resp(dmi_resp_bits_resp)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (resetn && dmi_req_valid && dmi_req_ready) req_cnt <= req_cnt + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_cmd(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
    cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    tick;
    cmd_valid = 0;
  endtask
  task automatic wait_req;
    int k = 0;
    while (!dmi_req_valid && k < 40) begin tick; k++; end
    if (!dmi_req_valid) begin cmps++; errs++; $display("FAIL wait_req: dmi_req_valid got 0 want 1 within 40 cycles"); end
  endtask
  task automatic ack_req;
    dmi_req_ready = 1;
    tick;
    dmi_req_ready = 0;
  endtask
  task automatic respond(input logic [31:0] d, input logic [1:0] r);
    int k = 0;
    while (!dmi_resp_ready && k < 40) begin tick; k++; end
    if (!dmi_resp_ready) begin cmps++; errs++; $display("FAIL wait_resp_ready: got 0 want 1 within 40 cycles"); end
    dmi_resp_valid = 1; dmi_resp_bits_data = d; dmi_resp_bits_resp = r;
    tick;
    dmi_resp_valid = 0;
  endtask
  task automatic accept_rsp;
    rsp_ready = 1;
    tick;
    rsp_ready = 0;
  endtask
  task automatic test_reset;
    resetn = 0;
    tick; tick;
    resetn = 1;
    cmps++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    cmps++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    cmps++; if (dmi_req_valid !== 1'b0) begin errs++; $display("FAIL reset_req_valid: got %b want 0", dmi_req_valid); end
    cmps++; if (dmi_resp_ready !== 1'b0) begin errs++; $display("FAIL reset_resp_ready: got %b want 0", dmi_resp_ready); end
    cmps++; if (rsp_data !== 32'd0) begin errs++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    cmps++; if (rsp_status !== 2'd0) begin errs++; $display("FAIL reset_rsp_status: got %0d want 0", rsp_status); end
  endtask
  task automatic test_read;
    do_cmd(2'd1, 7'h11, 32'd0);
    cmps++; if (dmi_req_valid !== 1'b1) begin errs++; $display("FAIL read_req_latency: got %b want 1", dmi_req_valid); end
    cmps++; if ({dmi_req_bits_op, dmi_req_bits_addr} !== {2'd1, 7'h11}) begin errs++; $display("FAIL read_req_payload: got op %0d addr %h want op 1 addr 11", dmi_req_bits_op, dmi_req_bits_addr); end
    ack_req;
    cmps++; if (dmi_resp_ready !== 1'b1 || dmi_req_valid !== 1'b0) begin errs++; $display("FAIL read_resp_phase: got resp_ready %b req_valid %b want 1 0", dmi_resp_ready, dmi_req_valid); end
    respond(32'h0000_3A2F, 2'd0);
    cmps++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL read_rsp_latency: got %b want 1", rsp_valid); end
    cmps++; if (rsp_data !== 32'h0000_3A2F || rsp_status !== 2'd0) begin errs++; $display("FAIL read_result: got %h/%0d want 00003a2f/0", rsp_data, rsp_status); end
    cmps++; if (dmi_resp_ready !== 1'b0 || cmd_ready !== 1'b0) begin errs++; $display("FAIL read_done_ready: got resp_ready %b cmd_ready %b want 0 0", dmi_resp_ready, cmd_ready); end
    accept_rsp;
    cmps++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errs++; $display("FAIL read_idle: got rsp_valid %b cmd_ready %b want 0 1", rsp_valid, cmd_ready); end
  endtask
  task automatic test_write_backpressure;
    n0 = req_cnt;
    do_cmd(2'd2, 7'h10, 32'h8000_0001);
    for (int i = 0; i < 5; i++) begin
      cmps++; if ({dmi_req_valid, dmi_req_bits_op, dmi_req_bits_addr, dmi_req_bits_data} !== {1'b1, 2'd2, 7'h10, 32'h8000_0001}) begin errs++; $display("FAIL write_stall_%0d: got v%b op %0d addr %h data %h want v1 op 2 addr 10 data 80000001", i, dmi_req_valid, dmi_req_bits_op, dmi_req_bits_addr, dmi_req_bits_data); end
      tick;
    end
    ack_req;
    respond(32'h0000_1234, 2'd0);
    cmps++; if (rsp_data !== 32'h0000_1234 || rsp_status !== 2'd0) begin errs++; $display("FAIL write_result: got %h/%0d want 00001234/0", rsp_data, rsp_status); end
    cmps++; if (req_cnt - n0 !== 1) begin errs++; $display("FAIL write_req_count: got %0d want 1", req_cnt - n0); end
    accept_rsp;
  endtask
  task automatic test_busy_retry;
    n0 = req_cnt;
    do_cmd(2'd1, 7'h05, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cmps++; if ({dmi_req_valid, dmi_req_bits_op, dmi_req_bits_addr} !== {1'b1, 2'd1, 7'h05}) begin errs++; $display("FAIL retry_req_%0d: got v%b op %0d addr %h want v1 op 1 addr 05", k, dmi_req_valid, dmi_req_bits_op, dmi_req_bits_addr); end
      wait_req;
      ack_req;
      respond(k < 2 ? 32'h0 : 32'h55, k < 2 ? 2'd3 : 2'd0);
    end
    cmps++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h55 || rsp_status !== 2'd0) begin errs++; $display("FAIL retry_result: got v%b %h/%0d want v1 00000055/0", rsp_valid, rsp_data, rsp_status); end
    cmps++; if (req_cnt - n0 !== 3) begin errs++; $display("FAIL retry_req_count: got %0d want 3", req_cnt - n0); end
    accept_rsp;
  endtask
  task automatic test_retry_exhaust;
    n0 = req_cnt;
    do_cmd(2'd1, 7'h22, 32'd0);
    for (int k = 0; k < 3; k++) begin
      wait_req;
      ack_req;
      respond(32'hDEAD_0000 + 32'(k), 2'd3);
    end
    cmps++; if (rsp_valid !== 1'b1 || rsp_status !== 2'd3 || rsp_data !== 32'hDEAD_0002) begin errs++; $display("FAIL exhaust_result: got v%b %h/%0d want v1 dead0002/3", rsp_valid, rsp_data, rsp_status); end
    cmps++; if (req_cnt - n0 !== 3 || dmi_req_valid !== 1'b0) begin errs++; $display("FAIL exhaust_req_count: got %0d valid %b want 3 0", req_cnt - n0, dmi_req_valid); end
    accept_rsp;
  endtask
  task automatic test_failed_and_nop;
    do_cmd(2'd3, 7'h01, 32'd0);
    cmps++; if (dmi_req_valid !== 1'b1 || dmi_req_bits_op !== 2'd0) begin errs++; $display("FAIL nop_map: got v%b op %0d want v1 op 0", dmi_req_valid, dmi_req_bits_op); end
    ack_req;
    respond(32'hCAFE, 2'd2);
    cmps++; if (rsp_status !== 2'd2 || rsp_data !== 32'hCAFE) begin errs++; $display("FAIL failed_resp: got %h/%0d want 0000cafe/2", rsp_data, rsp_status); end
    accept_rsp;
    do_cmd(2'd1, 7'h02, 32'd0);
    ack_req;
    respond(32'hBEEF, 2'd1);
    cmps++; if (rsp_status !== 2'd2 || rsp_data !== 32'hBEEF) begin errs++; $display("FAIL resp1_map: got %h/%0d want 0000beef/2", rsp_data, rsp_status); end
    accept_rsp;
  endtask
`ifdef DMI_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    do_cmd(2'd1, 7'h30, 32'd0);
    ack_req;
    repeat (15) tick;
    cmps++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL timeout_early: got %b want 0", rsp_valid); end
    tick;
    cmps++; if (rsp_valid !== 1'b1 || rsp_status !== 2'd1 || rsp_data !== 32'hBEEF) begin errs++; $display("FAIL timeout_result: got v%b %h/%0d want v1 0000beef/1", rsp_valid, rsp_data, rsp_status); end
    cmps++; if (dmi_resp_ready !== 1'b1 || cmd_ready !== 1'b0) begin errs++; $display("FAIL timeout_drain: got resp_ready %b cmd_ready %b want 1 0", dmi_resp_ready, cmd_ready); end
    accept_rsp;
    cmd_valid = 1; cmd_op = 2'd1; cmd_addr = 7'h31;
    tick; tick;
    cmd_valid = 0;
    cmps++; if (cmd_ready !== 1'b0 || dmi_req_valid !== 1'b0) begin errs++; $display("FAIL drain_block: got cmd_ready %b req_valid %b want 0 0", cmd_ready, dmi_req_valid); end
    dmi_resp_valid = 1; dmi_resp_bits_data = 32'hBAD; dmi_resp_bits_resp = 2'd0;
    tick;
    dmi_resp_valid = 0;
    cmps++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'hBEEF || dmi_resp_ready !== 1'b0) begin errs++; $display("FAIL drain_drop: got cmd_ready %b rsp_valid %b data %h resp_ready %b want 1 0 0000beef 0", cmd_ready, rsp_valid, rsp_data, dmi_resp_ready); end
    do_cmd(2'd1, 7'h31, 32'd0);
    ack_req;
    respond(32'h777, 2'd0);
    cmps++; if (rsp_data !== 32'h777 || rsp_status !== 2'd0) begin errs++; $display("FAIL after_timeout: got %h/%0d want 00000777/0", rsp_data, rsp_status); end
    accept_rsp;
  endtask
`endif
  task automatic test_mid_reset;
    do_cmd(2'd2, 7'h12, 32'd5);
    ack_req;
    resetn = 0;
    tick;
    resetn = 1;
    cmps++; if ({cmd_ready, rsp_valid, dmi_req_valid, dmi_resp_ready} !== 4'b1000) begin errs++; $display("FAIL midreset_ctl: got %b want 1000", {cmd_ready, rsp_valid, dmi_req_valid, dmi_resp_ready}); end
    cmps++; if (rsp_data !== 32'd0 || rsp_status !== 2'd0) begin errs++; $display("FAIL midreset_rsp: got %h/%0d want 0/0", rsp_data, rsp_status); end
    do_cmd(2'd1, 7'h13, 32'd0);
    cmps++; if (dmi_req_valid !== 1'b1 || dmi_req_bits_addr !== 7'h13) begin errs++; $display("FAIL midreset_req: got v%b addr %h want v1 13", dmi_req_valid, dmi_req_bits_addr); end
    ack_req;
    respond(32'h99, 2'd0);
    cmps++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h99 || rsp_status !== 2'd0) begin errs++; $display("FAIL midreset_next: got v%b %h/%0d want v1 00000099/0", rsp_valid, rsp_data, rsp_status); end
    accept_rsp;
  endtask
  task automatic test_back_to_back;
    cmd_valid = 1; cmd_op = 2'd1; cmd_addr = 7'h40; dmi_req_ready = 1; rsp_ready = 1;
    dmi_resp_valid = 1; dmi_resp_bits_data = 32'hA5; dmi_resp_bits_resp = 2'd0;
    n0 = req_cnt;
    repeat (8) tick;
    cmd_valid = 0; dmi_req_ready = 0; rsp_ready = 0; dmi_resp_valid = 0;
    cmps++; if (req_cnt - n0 !== 2) begin errs++; $display("FAIL b2b_turnaround: got %0d requests want 2 in 8 cycles", req_cnt - n0); end
    repeat (4) tick;
  endtask
  initial begin
    test_reset;
    test_read;
    test_write_backpressure;
    test_busy_retry;
    test_retry_exhaust;
    test_failed_and_nop;
`ifdef DMI_MASTER_TIMEOUT_EN
    test_timeout;
`endif
    test_mid_reset;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule

// File: doc/dmi_master.md
# dmi_master

Debug-module-interface (DMI) initiator: accepts single read/write commands from a host-side command port, issues them as DMI requests toward the core-complex debug slave (`debug_clockeddmi_dmi`), collects the response, and returns data plus status. It retries busy responses and optionally times out a stalled slave. It sits in the debug clock domain, between the host-side debug transport (JTAG/AXI-lite bridge) and the core-complex DMI slave port.

## Interface
Parameters:
- `ADDR_W`, 7: DMI address width.
- `MAX_RETRY`, 4: busy-response retries before giving up (0..15).
- `TIMEOUT`, 1024: cycles to wait for a DMI response (used only with timeout compiled in).

Ports:
- `clock`  in  1  sole clock; all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  command accepted when both high.
- `cmd_op`  in  2  0 = nop, 1 = read, 2 = write; 3 is treated as nop.
- `cmd_addr`  in  ADDR_W  DMI register address.
- `cmd_wdata`  in  32  write data.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  host accepts result.
- `rsp_data`  out  32  read data from the last DMI response.
- `rsp_status`  out  2  0 = ok, 1 = timeout, 2 = DMI failed, 3 = busy after retries exhausted.
- `dmi_req_valid` / `dmi_req_ready`  out / in  1  DMI request handshake.
- `dmi_req_bits_op` / `_addr` / `_data`  out  2 / ADDR_W / 32  DMI request payload.
- `dmi_resp_valid` / `dmi_resp_ready`  in / out  1  DMI response handshake.
- `dmi_resp_bits_data` / `_resp`  in  32 / 2  DMI response payload; resp 0 = ok, 2 = failed, 3 = busy.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - `cmd_ready` = 1 (except while draining, see Timing).
  - On a cmd handshake, latch op/addr/wdata, clear the retry counter, go to REQ.
- REQ:
  - `dmi_req_valid` = 1 with the latched payload; payload stays stable until `dmi_req_ready`.
  - On the req handshake, go to RESP.
- RESP:
  - `dmi_resp_ready` = 1.
  - On `dmi_resp_valid` with resp = 3 and retry count < MAX_RETRY: increment the count and go to REQ to reissue the identical request.
  - Any other response: latch data; status = resp (resp 1 maps to 2); go to DONE.
  - Busy response with count = MAX_RETRY: status 3, go to DONE.
- DONE:
  - `rsp_valid` = 1; `rsp_data`/`rsp_status` stay stable.
  - On `rsp_ready`, go to IDLE.
- `rsp_data` is updated on every final response, including writes, and holds its value otherwise.
- Retry counter is 4 bits. MAX_RETRY = 0 means no retry.

## Timing
- Reset (`resetn` = 0 at an edge):
  - state = IDLE; `cmd_ready` = 1; `rsp_valid`, `dmi_req_valid`, `dmi_resp_ready` = 0.
  - `rsp_data` = 0, `rsp_status` = 0; retry and timeout counters = 0; drain flag = 0.
  - Reset mid-transaction abandons it with no response.
- Latency:
  - A cmd handshake at cycle N drives `dmi_req_valid` at N+1.
  - A response handshake at cycle M drives `rsp_valid` at M+1.
  - A retry reasserts `dmi_req_valid` the cycle after the busy response.
- All outputs are registered or decoded from state only; there is no combinational path from `*_valid`/`*_ready` inputs to outputs.
- `dmi_req_valid` never deasserts before `dmi_req_ready`.
- `dmi_resp_ready` is never high outside RESP, except while draining.
- `rsp_ready` held high in DONE: IDLE is entered next cycle and a new cmd can be accepted that same IDLE cycle, giving a minimum 4-cycle turnaround with a zero-wait slave.

## Configuration
- `DMI_MASTER_TIMEOUT_EN` defined:
  - A 16-bit counter runs in RESP and clears on entry.
  - Reaching TIMEOUT-1 without `dmi_resp_valid`: go to DONE with status 1 and set the drain flag.
  - While drain = 1: `dmi_resp_ready` = 1 and `cmd_ready` = 0. The next `dmi_resp_valid` is discarded and clears drain.
  - A response arriving in the same cycle as the timeout expiry wins; it is handled as a normal response.
- `DMI_MASTER_TIMEOUT_EN` undefined: RESP waits indefinitely, status 1 is never produced, and the drain logic is absent.

## Test plan
- Read, zero-wait slave: cmd op 1, addr 0x11 at cycle 0 → `dmi_req_valid` at cycle 1 with op 1, addr 0x11; slave returns data 0x0000_3A2F, resp 0 → `rsp_valid` one cycle later, data 0x3A2F, status 0.
- Write with backpressure: op 2, addr 0x10, wdata 0x8000_0001; `dmi_req_ready` held low 5 cycles → payload stable throughout, exactly one request issued, status 0.
- Busy retry: slave answers resp 3 twice, then resp 0 with data 0x55 → three identical requests observed, data 0x55, status 0.
- Retry exhaustion, MAX_RETRY = 2: slave always answers busy → exactly 3 requests, then status 3.
- Timeout (macro on, TIMEOUT = 16): slave never responds → status 1 at cycle 16 after entering RESP; `cmd_ready` stays 0 until a late response arrives, which is dropped; the next read completes normally.
- Mid-transaction reset: `resetn` low for 1 cycle while in RESP → all outputs return to reset values next cycle; the next command completes normally.
